// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, access-size encodings and alignment helpers
package mem_stage_pkg;

   localparam int DEF_SIZE_DATA = 32;
   localparam int DEF_SIZE_REG  = 5;
   localparam int DEF_MEM_DEPTH = 32;
   localparam int LANES         = 4;

   // Encoding of i_width; 11 behaves exactly like a word access.
   typedef enum logic [1:0] {
      ACC_BYTE     = 2'b00,
      ACC_HALF     = 2'b01,
      ACC_WORD     = 2'b10,
      ACC_WORD_ALT = 2'b11
   } acc_width_e;

   // Bytes can sit anywhere; halves need an even address; words need a 4-byte boundary.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] low);
      logic r;
      r = 1'b0;
      case (acc_width_e'(width))
         ACC_BYTE: r = 1'b0;
         ACC_HALF: r = low[0];
         default:  r = (low != 2'b00);
      endcase
      return r;
   endfunction

   // Byte lanes touched by an access of the given size at the given byte offset.
   function automatic logic [LANES-1:0] lane_enables(input logic [1:0] width, input logic [1:0] low);
      logic [LANES-1:0] be;
      be = 4'b0000;
      case (acc_width_e'(width))
         ACC_BYTE: be = 4'b0001 << low;
         ACC_HALF: be = low[1] ? 4'b1100 : 4'b0011;
         default:  be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - pipeline-side request/response bundle of the memory stage
interface mem_stage_if
   import mem_stage_pkg::*;
#(
   parameter int SIZE_DATA = DEF_SIZE_DATA,
   parameter int SIZE_REG  = DEF_SIZE_REG
);
   logic                 i_enable;
   logic                 i_mem_read;
   logic                 i_mem_write;
   logic [1:0]           i_width;
   logic                 i_unsigned;
   logic [SIZE_DATA-1:0] i_alu_result;
   logic [SIZE_DATA-1:0] i_store_data;
   logic [SIZE_REG-1:0]  i_rd;
   logic                 i_reg_write;

   logic [SIZE_DATA-1:0] o_load_data;
   logic [SIZE_DATA-1:0] o_alu_result;
   logic [SIZE_REG-1:0]  o_rd;
   logic                 o_reg_write;

   // Pipeline (EX/MEM side) drives requests and consumes the write-back values.
   modport master (
      output i_enable, i_mem_read, i_mem_write, i_width, i_unsigned,
             i_alu_result, i_store_data, i_rd, i_reg_write,
      input  o_load_data, o_alu_result, o_rd, o_reg_write
   );

   // Memory stage consumes requests and produces the MEM/WB values.
   modport slave (
      input  i_enable, i_mem_read, i_mem_write, i_width, i_unsigned,
             i_alu_result, i_store_data, i_rd, i_reg_write,
      output o_load_data, o_alu_result, o_rd, o_reg_write
   );

endinterface

// File: rtl/mem_stage_dmem.sv
// rtl/mem_stage_dmem.sv - data memory: byte-enable sync write, two async reads, sync clear
module mem_stage_dmem
   import mem_stage_pkg::*;
#(
   parameter int SIZE_DATA = DEF_SIZE_DATA,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
   input  logic                         clk,
   input  logic                         clear,
   input  logic [LANES-1:0]             be,
   input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
   input  logic [SIZE_DATA-1:0]         wdata,
   input  logic [$clog2(MEM_DEPTH)-1:0] raddr_a,
   output logic [SIZE_DATA-1:0]         rdata_a,
   input  logic [$clog2(MEM_DEPTH)-1:0] raddr_b,
   output logic [SIZE_DATA-1:0]         rdata_b
);

   logic [SIZE_DATA-1:0] mem [MEM_DEPTH];

   // Clear wins over any write in the same cycle; otherwise only enabled byte lanes change.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (be[k]) begin
               mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
         end
      end
   end

   // Both read ports see current contents, so a same-cycle store is not yet visible.
   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: aligned loads/stores, status counters, sticky misalign flag
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int SIZE_DATA = DEF_SIZE_DATA,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int SIZE_REG  = DEF_SIZE_REG
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   mem_stage_if.slave                   bus,
   input  logic [$clog2(MEM_DEPTH)-1:0] i_dbg_addr,
   output logic [SIZE_DATA-1:0]         o_dbg_data,
   output logic                         o_misaligned,
   output logic [SIZE_DATA-1:0]         o_misaligned_addr,
   output logic [15:0]                  o_load_count,
   output logic [15:0]                  o_store_count
);

   localparam int ADDR_W = $clog2(MEM_DEPTH);

   logic [1:0]           byte_off;
   logic [ADDR_W-1:0]    word_idx;
   logic                 misaligned;
   logic                 mem_access;
   logic                 load_ok;
   logic                 store_ok;
   logic [LANES-1:0]     wr_be;
   logic [SIZE_DATA-1:0] wr_data;
   logic [SIZE_DATA-1:0] rd_word;
   logic [SIZE_DATA-1:0] lane_data;
   logic [7:0]           rd_byte;
   logic [15:0]          rd_half;
   logic                 unused_addr_bits;

   // Addresses wrap modulo the memory size; the bits above the word index are don't-care.
   assign byte_off         = bus.i_alu_result[1:0];
   assign word_idx         = bus.i_alu_result[ADDR_W+1:2];
   assign unused_addr_bits = ^bus.i_alu_result[SIZE_DATA-1:ADDR_W+2];

   assign misaligned = is_misaligned(bus.i_width, byte_off);
   assign mem_access = bus.i_mem_read | bus.i_mem_write;
   assign load_ok    = bus.i_enable & bus.i_mem_read & ~misaligned;
   assign store_ok   = bus.i_enable & bus.i_mem_write & ~misaligned;

   // Replicate low-aligned store data across lanes so the byte enables pick the right copy.
   always_comb begin
      wr_data = bus.i_store_data;
      case (acc_width_e'(bus.i_width))
         ACC_BYTE: wr_data = {4{bus.i_store_data[7:0]}};
         ACC_HALF: wr_data = {2{bus.i_store_data[15:0]}};
         default:  wr_data = bus.i_store_data;
      endcase
   end

   assign wr_be = store_ok ? lane_enables(bus.i_width, byte_off) : '0;

   mem_stage_dmem #(
      .SIZE_DATA (SIZE_DATA),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_dmem (
      .clk     (i_clk),
      .clear   (i_reset),
      .be      (wr_be),
      .waddr   (word_idx),
      .wdata   (wr_data),
      .raddr_a (word_idx),
      .rdata_a (rd_word),
      .raddr_b (i_dbg_addr),
      .rdata_b (o_dbg_data)
   );

   assign rd_byte = rd_word[8*byte_off +: 8];
   assign rd_half = rd_word[16*byte_off[1] +: 16];

   // Pick the addressed lane of the read word and sign- or zero-extend it.
   always_comb begin
      lane_data = rd_word;
      case (acc_width_e'(bus.i_width))
         ACC_BYTE: lane_data = bus.i_unsigned ? {{(SIZE_DATA-8){1'b0}}, rd_byte}
                                              : {{(SIZE_DATA-8){rd_byte[7]}}, rd_byte};
         ACC_HALF: lane_data = bus.i_unsigned ? {{(SIZE_DATA-16){1'b0}}, rd_half}
                                              : {{(SIZE_DATA-16){rd_half[15]}}, rd_half};
         default:  lane_data = rd_word;
      endcase
   end

   // A misaligned load returns zero and must not reach the register file.
   assign bus.o_load_data  = (bus.i_mem_read && !misaligned) ? lane_data : '0;
   assign bus.o_reg_write  = bus.i_reg_write & ~(bus.i_mem_read & misaligned);
   assign bus.o_alu_result = bus.i_alu_result;
   assign bus.o_rd         = bus.i_rd;

   // Sticky record of the first misaligned access; only reset clears it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_misaligned      <= 1'b0;
         o_misaligned_addr <= '0;
      end else if (bus.i_enable && mem_access && misaligned && !o_misaligned) begin
         o_misaligned      <= 1'b1;
         o_misaligned_addr <= bus.i_alu_result;
      end
   end

   // Saturating counts of enabled, aligned loads and stores.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_load_count  <= '0;
         o_store_count <= '0;
      end else begin
         if (load_ok && o_load_count != 16'hFFFF) begin
            o_load_count <= o_load_count + 16'd1;
         end
         if (store_ok && o_store_count != 16'hFFFF) begin
            o_store_count <= o_store_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - table-driven scoreboard bench for mem_stage
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        mis;
   logic [31:0] mis_addr;
   logic [15:0] lcnt;
   logic [15:0] scnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_stage_if #(.SIZE_DATA(32), .SIZE_REG(5)) bus ();

   mem_stage #(
      .SIZE_DATA (32),
      .MEM_DEPTH (32),
      .SIZE_REG  (5)
   ) dut (
      .i_clk             (clk),
      .i_reset           (rst),
      .bus               (bus),
      .i_dbg_addr        (dbg_addr),
      .o_dbg_data        (dbg_data),
      .o_misaligned      (mis),
      .o_misaligned_addr (mis_addr),
      .o_load_count      (lcnt),
      .o_store_count     (scnt)
   );

   typedef struct {
      logic        rd_en;
      logic        wr_en;
      logic [1:0]  width;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] exp_load;
      logic        exp_rw;
   } vec_t;

   typedef struct {
      logic [31:0] load;
      logic        rw;
      logic [31:0] alu;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[16];
   vec_t v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.i_enable     = 1'b0;
      bus.i_mem_read   = 1'b0;
      bus.i_mem_write  = 1'b0;
      bus.i_width      = 2'b00;
      bus.i_unsigned   = 1'b0;
      bus.i_alu_result = 32'h0;
      bus.i_store_data = 32'h0;
      bus.i_rd         = 5'd0;
      bus.i_reg_write  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic apply(input vec_t t, input logic en, input string tag);
      exp_t e;
      bus.i_enable     = en;
      bus.i_mem_read   = t.rd_en;
      bus.i_mem_write  = t.wr_en;
      bus.i_width      = t.width;
      bus.i_unsigned   = t.uns;
      bus.i_alu_result = t.addr;
      bus.i_store_data = t.sdata;
      bus.i_rd         = t.rd;
      bus.i_reg_write  = t.rw;
      sb_q.push_back('{t.exp_load, t.exp_rw, t.addr, t.rd});
      @(negedge clk);
      e = sb_q.pop_front();
      chk({tag, " load_data"}, bus.o_load_data, e.load);
      chk({tag, " reg_write"}, 32'(bus.o_reg_write), 32'(e.rw));
      chk({tag, " alu_result"}, bus.o_alu_result, e.alu);
      chk({tag, " rd"}, 32'(bus.o_rd), 32'(e.rd));
      tick();
   endtask

   initial begin
      rst      = 1'b1;
      dbg_addr = 5'd0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("reset load_count", 32'(lcnt), 32'h0);
      chk("reset store_count", 32'(scnt), 32'h0);
      chk("reset misaligned", 32'(mis), 32'h0);
      chk("reset misaligned_addr", mis_addr, 32'h0);
      dbg_addr = 5'd2;
      #1;
      chk("reset dbg word2", dbg_data, 32'h0);

      //          rd    wr    width  uns   addr    sdata         rd     rw    exp_load      exp_rw
      vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 5'd0,  1'b0, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        5'd1,  1'b1, 32'hDEADBEEF, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        5'd2,  1'b1, 32'hFFFFFFBE, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        5'd3,  1'b1, 32'h000000BE, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        5'd4,  1'b1, 32'hFFFFDEAD, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h08, 32'h0,        5'd5,  1'b1, 32'h0000BEEF, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0B, 32'hFFFFFF11, 5'd0,  1'b0, 32'h00000000, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        5'd6,  1'b1, 32'h11ADBEEF, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0,        5'd7,  1'b1, 32'h00000011, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 5'd8,  1'b1, 32'h00000000, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        5'd9,  1'b1, 32'h12345678, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234CAFE, 5'd0,  1'b0, 32'h00000000, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        5'd10, 1'b1, 32'hCAFE5678, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        5'd11, 1'b1, 32'hFFFFCAFE, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h84, 32'hA5A5A5A5, 5'd0,  1'b1, 32'h00000000, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h04, 32'h0,        5'd12, 1'b1, 32'hA5A5A5A5, 1'b1};

      for (int i = 0; i < 16; i++) begin
         apply(vecs[i], 1'b1, $sformatf("vec%0d", i));
      end
      chk("table store_count", 32'(scnt), 32'd5);
      chk("table load_count", 32'(lcnt), 32'd12);
      chk("table misaligned", 32'(mis), 32'h0);

      v = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 5'd3, 1'b1, 32'h0, 1'b0};
      apply(v, 1'b1, "mis_word_load");
      chk("mis flag set", 32'(mis), 32'h1);
      chk("mis addr captured", mis_addr, 32'h6);
      v = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 5'd4, 1'b1, 32'h0, 1'b0};
      apply(v, 1'b1, "mis_half_load");
      chk("mis addr kept", mis_addr, 32'h6);
      v = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h0, 1'b0};
      apply(v, 1'b1, "mis_word_store");
      v = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 32'hCAFE5678, 1'b1};
      apply(v, 1'b1, "after_mis_store");
      chk("mis store_count", 32'(scnt), 32'd5);
      chk("mis load_count", 32'(lcnt), 32'd13);

      dbg_addr = 5'd2;
      #1;
      chk("dbg word2", dbg_data, 32'h11ADBEEF);
      dbg_addr = 5'd1;
      #1;
      chk("dbg word1 wrap", dbg_data, 32'hA5A5A5A5);

      v = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h55555555, 5'd0, 1'b0, 32'h0, 1'b0};
      apply(v, 1'b0, "disabled_store");
      v = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 5'd6, 1'b1, 32'h11ADBEEF, 1'b1};
      apply(v, 1'b1, "after_disabled");
      chk("dis store_count", 32'(scnt), 32'd5);
      chk("dis load_count", 32'(lcnt), 32'd14);

      bus.i_enable     = 1'b1;
      bus.i_mem_write  = 1'b1;
      bus.i_width      = 2'b10;
      bus.i_alu_result = 32'h08;
      bus.i_store_data = 32'h77777777;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      dbg_addr = 5'd2;
      #1;
      chk("rst+store word2", dbg_data, 32'h0);
      dbg_addr = 5'd1;
      #1;
      chk("rst word1", dbg_data, 32'h0);
      chk("rst load_count", 32'(lcnt), 32'h0);
      chk("rst store_count", 32'(scnt), 32'h0);
      chk("rst misaligned", 32'(mis), 32'h0);
      chk("rst misaligned_addr", mis_addr, 32'h0);

      bus.i_enable     = 1'b1;
      bus.i_mem_read   = 1'b1;
      bus.i_width      = 2'b10;
      bus.i_alu_result = 32'h0;
      repeat (65535) @(posedge clk);
      #1;
      chk("load_count at max", 32'(lcnt), 32'h0000FFFF);
      @(posedge clk);
      #1;
      chk("load_count saturated", 32'(lcnt), 32'h0000FFFF);
      chk("sat store_count", 32'(scnt), 32'h0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
